// File: rtl/instr_decode_pipe.sv
// One-stage instruction decoder with chained wide-immediate LOAD accumulation.
// Decode outputs are valid the cycle after capture; stall holds the decode register, flush squashes it.
module instr_decode_pipe #(
    parameter int DATA_W  = 8,
    parameter int IMM_EXT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              stall,
    input  logic              flush,
    output logic              dec_valid,
    output logic              jmp,
    output logic              jmp_nz,
    output logic              i_sel,
    output logic              x_sel,
    output logic              y_sel,
    output logic [3:0]        ir_nibble,
    output logic [2:0]        alu_func,
    output logic [3:0]        source_sel,
    output logic [8:0]        reg_en,
    output logic [DATA_W-1:0] imm
);

    localparam int NIB      = DATA_W / 4;
    localparam bit CHAIN_EN = (IMM_EXT != 0) && (DATA_W > 4);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CHAIN = 1'b1;

    localparam logic [3:0] SRC_IMM  = 4'd8;
    localparam logic [3:0] SRC_IDLE = 4'd10;

    logic [7:0]        ir;
    logic              vld_q;
    logic [0:0]        state;
    logic [2:0]        last_dst;
    logic [2:0]        cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] imm_hold;

    logic              is_load;
    logic              is_move;
    logic              is_alu;
    logic              is_jmp;
    logic              is_jnz;
    logic [2:0]        dst;
    logic [2:0]        src;
    logic              retire;
    logic              extend;
    logic [DATA_W-1:0] nib_ext;
    logic [DATA_W-1:0] imm_la;

    // Decode register: flush wins over stall so a held instruction can be squashed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir    <= 8'h00;
            vld_q <= 1'b0;
        end else if (!stall) begin
            ir    <= instr_in;
            vld_q <= instr_valid && !flush;
        end else begin
            vld_q <= vld_q && !flush;
        end
    end

    assign instr_ready = reset_n && !stall;
    assign dec_valid   = vld_q;
    assign ir_nibble   = ir[3:0];
    assign alu_func    = ir[2:0];

    assign is_load = !ir[7];
    assign is_move = (ir[7:6] == 2'b10);
    assign is_alu  = (ir[7:5] == 3'b110);
    assign is_jmp  = (ir[7:4] == 4'b1110);
    assign is_jnz  = (ir[7:4] == 4'b1111);
    assign dst     = is_load ? ir[6:4] : ir[5:3];
    assign src     = ir[2:0];
    assign retire  = vld_q && !stall;

    // Look-ahead: imm shows what acc will hold once this LOAD retires.
    assign nib_ext = DATA_W'(ir[3:0]);
    assign extend  = CHAIN_EN && (state == ST_CHAIN) && (dst == last_dst) && (cnt < 3'(NIB));
    assign imm_la  = extend ? ((acc << 4) | nib_ext) : nib_ext;
    assign imm     = (vld_q && is_load) ? imm_la : imm_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            last_dst <= 3'd0;
            cnt      <= 3'd0;
            acc      <= '0;
            imm_hold <= '0;
        end else begin
            imm_hold <= imm;
            if (flush) begin
                state <= ST_IDLE;
                cnt   <= 3'd0;
            end else if (retire) begin
                if (CHAIN_EN && is_load) begin
                    state    <= ST_CHAIN;
                    last_dst <= dst;
                    acc      <= imm_la;
                    cnt      <= extend ? (cnt + 3'd1) : 3'd1;
                end else begin
                    state <= ST_IDLE;
                end
            end
        end
    end

    always_comb begin
        jmp        = 1'b0;
        jmp_nz     = 1'b0;
        i_sel      = 1'b1;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        source_sel = SRC_IDLE;
        reg_en     = 9'h000;
        if (!reset_n) begin
            reg_en = 9'h1FF;
            i_sel  = 1'b0;
        end else if (vld_q) begin
            jmp        = is_jmp;
            jmp_nz     = is_jnz;
            source_sel = 4'd0;
            if (is_load || is_move) begin
                case (dst)
                    3'd4:    reg_en = 9'h100;
                    3'd7:    reg_en = 9'h0C0;
                    default: reg_en = 9'(1) << dst;
                endcase
                if (dst == 3'd6) begin
                    i_sel = 1'b0;
                end
            end
            if (is_load) begin
                source_sel = SRC_IMM;
            end
            if (is_move) begin
                source_sel = {1'b0, src};
                if (src == 3'd7 && dst != 3'd6) begin
                    reg_en[6] = 1'b1;
                end
            end
            if (is_alu) begin
                reg_en = 9'h010;
                x_sel  = ir[4];
                y_sel  = ir[3];
            end
        end
    end

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Randomized and directed checks of instr_decode_pipe against a transaction-level model.
module tb_instr_decode_pipe;

    localparam int DATA_W = 8;
    localparam int NIB    = DATA_W / 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [7:0]        instr_in;
    logic              instr_valid;
    logic              instr_ready;
    logic              stall;
    logic              flush;
    logic              dec_valid;
    logic              jmp;
    logic              jmp_nz;
    logic              i_sel;
    logic              x_sel;
    logic              y_sel;
    logic [3:0]        ir_nibble;
    logic [2:0]        alu_func;
    logic [3:0]        source_sel;
    logic [8:0]        reg_en;
    logic [DATA_W-1:0] imm;

    always #5 clk = ~clk;

    instr_decode_pipe #(.DATA_W(DATA_W), .IMM_EXT(1)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .stall       (stall),
        .flush       (flush),
        .dec_valid   (dec_valid),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .i_sel       (i_sel),
        .x_sel       (x_sel),
        .y_sel       (y_sel),
        .ir_nibble   (ir_nibble),
        .alu_func    (alu_func),
        .source_sel  (source_sel),
        .reg_en      (reg_en),
        .imm         (imm)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: the instruction in decode plus the current immediate chain as a value and a length.
    logic [7:0] m_ir;
    bit         m_vld;
    bit         m_in_chain;
    int         m_len;
    int         m_acc;
    int         m_last;
    int         m_hold;

    task automatic m_reset();
        m_ir = 8'h00; m_vld = 0; m_in_chain = 0; m_len = 0; m_acc = 0; m_last = 0; m_hold = 0;
    endtask

    function automatic bit m_extends();
        return m_in_chain && (int'(m_ir[6:4]) == m_last) && (m_len < NIB);
    endfunction

    function automatic int m_lookahead();
        if (m_extends())
            return (m_acc * 16 + int'(m_ir[3:0])) % (1 << DATA_W);
        return int'(m_ir[3:0]);
    endfunction

    function automatic int m_imm();
        if (m_vld && !m_ir[7])
            return m_lookahead();
        return m_hold;
    endfunction

    task automatic check_all();
        int  map [8];
        int  dst, src, e_en, e_src, e_isel, e_x, e_y, e_j, e_jnz;
        bit  load, move, alu;
        map   = '{0, 1, 2, 3, 8, 5, 6, 7};
        load  = !m_ir[7];
        move  = (m_ir[7:6] == 2'b10);
        alu   = (m_ir[7:5] == 3'b110);
        dst   = load ? int'(m_ir[6:4]) : int'(m_ir[5:3]);
        src   = int'(m_ir[2:0]);
        e_en = 0; e_src = 10; e_isel = 1; e_x = 0; e_y = 0; e_j = 0; e_jnz = 0;
        if (m_vld) begin
            e_j   = (m_ir[7:4] == 4'hE) ? 1 : 0;
            e_jnz = (m_ir[7:4] == 4'hF) ? 1 : 0;
            e_src = 0;
            if (load || move) begin
                e_en = 1 << map[dst];
                if (dst == 7) e_en = e_en | 'h40;
                if (dst == 6) e_isel = 0;
            end
            if (load) e_src = 8;
            if (move) begin
                e_src = src;
                if (src == 7 && dst != 6) e_en = e_en | 'h40;
            end
            if (alu) begin
                e_en = 'h10;
                e_x  = int'(m_ir[4]);
                e_y  = int'(m_ir[3]);
            end
        end
        chk("dec_valid",   32'(dec_valid),   32'(m_vld));
        chk("instr_ready", 32'(instr_ready), 32'(!stall));
        chk("reg_en",      32'(reg_en),      32'(e_en));
        chk("source_sel",  32'(source_sel),  32'(e_src));
        chk("i_sel",       32'(i_sel),       32'(e_isel));
        chk("x_sel",       32'(x_sel),       32'(e_x));
        chk("y_sel",       32'(y_sel),       32'(e_y));
        chk("jmp",         32'(jmp),         32'(e_j));
        chk("jmp_nz",      32'(jmp_nz),      32'(e_jnz));
        chk("ir_nibble",   32'(ir_nibble),   32'(m_ir[3:0]));
        chk("alu_func",    32'(alu_func),    32'(m_ir[2:0]));
        chk("imm",         32'(imm),         32'(m_imm()));
    endtask

    task automatic model_edge();
        int  imm_now;
        bit  retire;
        imm_now = m_imm();
        retire  = m_vld && !stall;
        if (flush) begin
            m_in_chain = 0;
            m_len      = 0;
        end else if (retire) begin
            if (!m_ir[7]) begin
                m_len      = m_extends() ? m_len + 1 : 1;
                m_acc      = imm_now;
                m_last     = int'(m_ir[6:4]);
                m_in_chain = 1;
            end else begin
                m_in_chain = 0;
            end
        end
        m_hold = imm_now;
        if (!stall) begin
            m_ir  = instr_in;
            m_vld = instr_valid && !flush;
        end else begin
            m_vld = m_vld && !flush;
        end
    endtask

    // Apply inputs, check the pre-edge outputs, clock once, advance the model.
    task automatic cycle(input logic [7:0] ins, input bit v, input bit s, input bit f);
        instr_in = ins; instr_valid = v; stall = s; flush = f;
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ins;
        int         r;
        reset_n = 1'b0; instr_in = 8'h00; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        m_reset();
        #1;
        chk("rst_reg_en",      32'(reg_en),      32'h1FF);
        chk("rst_source_sel",  32'(source_sel),  32'd10);
        chk("rst_instr_ready", 32'(instr_ready), 32'd0);
        chk("rst_i_sel",       32'(i_sel),       32'd0);
        chk("rst_jmp",         32'(jmp),         32'd0);
        chk("rst_dec_valid",   32'(dec_valid),   32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        #1;

        // Two-nibble chain then restart on a full chain.
        cycle(8'h03, 1, 0, 0);
        chk("chain_imm1",    32'(imm),        32'h03);
        chk("chain_en1",     32'(reg_en),     32'h001);
        chk("chain_src1",    32'(source_sel), 32'd8);
        cycle(8'h0A, 1, 0, 0);
        chk("chain_imm2",    32'(imm),        32'h3A);
        chk("chain_en2",     32'(reg_en),     32'h001);
        cycle(8'h05, 1, 0, 0);
        chk("chain_restart", 32'(imm),        32'h05);

        // Special register enables.
        cycle(8'h72, 1, 0, 0);
        chk("load_dm_en",    32'(reg_en),     32'h0C0);
        cycle(8'hA4, 1, 0, 0);
        chk("mov_r_o_en",    32'(reg_en),     32'h100);
        chk("mov_r_o_src",   32'(source_sel), 32'd4);
        cycle(8'hB7, 1, 0, 0);
        chk("mov_dm_i_en",   32'(reg_en),     32'h040);
        chk("mov_dm_i_isel", 32'(i_sel),      32'd0);

        // Jump held under stall, then squashed by flush.
        cycle(8'hE5, 1, 0, 0);
        chk("jmp_capture", 32'(jmp), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(8'h12, 1, 1, 0);
            chk("jmp_stall_held",  32'(jmp),         32'd1);
            chk("jmp_stall_ir",    32'(ir_nibble),   32'd5);
            chk("jmp_stall_ready", 32'(instr_ready), 32'd0);
        end
        cycle(8'h12, 1, 1, 1);
        chk("flush_dec_valid", 32'(dec_valid), 32'd0);
        chk("flush_jmp",       32'(jmp),       32'd0);

        // Bubbles preserve a chain; a non-LOAD breaks it.
        cycle(8'h21, 1, 0, 0);
        cycle(8'h00, 0, 0, 0);
        chk("bubble_imm_hold", 32'(imm), 32'h01);
        cycle(8'h2F, 1, 0, 0);
        chk("bubble_chain", 32'(imm), 32'h1F);
        cycle(8'h21, 1, 0, 0);
        cycle(8'hC0, 1, 0, 0);
        cycle(8'h2F, 1, 0, 0);
        chk("alu_breaks_chain", 32'(imm), 32'h0F);

        // Asynchronous reset mid-chain.
        cycle(8'h33, 1, 0, 0);
        cycle(8'h34, 1, 0, 0);
        reset_n = 1'b0;
        #1;
        chk("arst_reg_en",    32'(reg_en),     32'h1FF);
        chk("arst_dec_valid", 32'(dec_valid),  32'd0);
        chk("arst_src",       32'(source_sel), 32'd10);
        m_reset();
        #1 reset_n = 1'b1;
        cycle(8'h37, 1, 0, 0);
        chk("post_rst_imm", 32'(imm), 32'h07);

        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)       ins = {1'b0, 3'($urandom_range(0, 2)), 4'($urandom)};
            else if (r < 7)  ins = {2'b10, 6'($urandom)};
            else if (r < 8)  ins = {3'b110, 5'($urandom)};
            else             ins = {3'b111, 5'($urandom)};
            cycle(ins, ($urandom % 10) < 8, ($urandom % 10) < 2, ($urandom % 16) == 0);
        end
        cycle(8'h00, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
